div_stage_unit: RTL and testbench

Execute-stage multi-cycle divider for the 5-stage MIPS pipeline. It is directly downstream of the controller: it decodes alucontrolE for DIV/DIVU and performs radix-2 restoring division on the forwarded operands. It produces the {HI,LO} result and a stall request for the hazard unit. It also honours pipeline flush (annul) and external execute-stage holds.

---
 rtl/div_stage_unit.sv | 129 ++++++++++++
 tb/tb_div_stage_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_stage_unit.sv
// rtl/div_stage_unit.sv - execute-stage radix-2 restoring divider for DIV/DIVU
// Produces {HI=remainder, LO=quotient}, a stall request while busy, and honours annul/hold.
module div_stage_unit #(
    parameter int         WIDTH     = 32,
    parameter logic [7:0] DIV_CODE  = 8'b00011010,
    parameter logic [7:0] DIVU_CODE = 8'b00011011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         alucontrolE,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               annul,
    input  logic               holdE,
    output logic               div_stallE,
    output logic               div_readyE,
    output logic [2*WIDTH-1:0] hiloE
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ON, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo, dvsr, rem;
    logic             neg_q, neg_r;

    logic             div_op, signed_op, start, by_zero, last_step;
    logic [WIDTH-1:0] abs_a, abs_b, quo_step, rem_step;
    logic [WIDTH:0]   trial;

    assign div_op    = (alucontrolE == DIV_CODE) || (alucontrolE == DIVU_CODE);
    assign signed_op = (alucontrolE == DIV_CODE);
    assign start     = div_op && !annul;
    assign by_zero   = (srcb == '0);
    assign last_step = (count == CW'(WIDTH - 1));

    // Magnitudes are taken as WIDTH-bit unsigned, so the most negative value maps to itself.
    assign abs_a = (signed_op && srca[WIDTH-1]) ? -srca : srca;
    assign abs_b = (signed_op && srcb[WIDTH-1]) ? -srcb : srcb;

    // rem < dvsr holds invariantly, so the trial difference fits a WIDTH+1 bit signed range.
    assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};

    always_comb begin
        rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
        quo_step = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], 1'b1};
        end
    end

    assign div_stallE = div_op && (state != DONE) && !annul;
    assign div_readyE = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = by_zero ? DONE : ON;
                end
            end
            ON: begin
                if (annul) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (!(holdE && !annul)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            quo   <= '0;
            dvsr  <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hiloE <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && by_zero) begin
                        hiloE <= {srca, {WIDTH{1'b1}}};
                    end else if (start) begin
                        quo   <= abs_a;
                        dvsr  <= abs_b;
                        rem   <= '0;
                        count <= '0;
                        neg_q <= signed_op && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r <= signed_op && srca[WIDTH-1];
                    end
                end
                ON: begin
                    if (annul) begin
                        count <= '0;
                    end else begin
                        quo   <= quo_step;
                        rem   <= rem_step;
                        count <= count + CW'(1);
                        if (last_step) begin
                            hiloE <= {neg_r ? -rem_step : rem_step,
                                      neg_q ? -quo_step : quo_step};
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_stage_unit.sv
// tb/tb_div_stage_unit.sv - self-checking bench for div_stage_unit
// Directed cases plus a random sweep, checked against a queued reference scoreboard.
module tb_div_stage_unit;
    localparam logic [7:0] DIV  = 8'b00011010;
    localparam logic [7:0] DIVU = 8'b00011011;
    localparam logic [7:0] ADD  = 8'b00100000;

    logic        clk;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic [31:0] srca, srcb;
    logic        annul, holdE;
    logic        div_stallE, div_readyE;
    logic [63:0] hiloE;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    div_stage_unit dut (
        .clk        (clk),
        .rst        (rst),
        .alucontrolE(alucontrolE),
        .srca       (srca),
        .srcb       (srcb),
        .annul      (annul),
        .holdE      (holdE),
        .div_stallE (div_stallE),
        .div_readyE (div_readyE),
        .hiloE      (hiloE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == DIVU) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    // Called at #1 after a posedge with the unit idle; returns the same way, op deasserted.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall);
        int stalls;
        bit done;
        logic [63:0] exp;
        exp_q.push_back(model(op, a, b));
        alucontrolE = op;
        srca = a;
        srcb = b;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (div_readyE) begin
                done = 1'b1;
                exp = exp_q.pop_front();
                chk("hilo", hiloE, exp);
                chk("stall_cycles", 64'(stalls), 64'(exp_stall));
            end else if (div_stallE) begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        alucontrolE = ADD;
        if (!done) begin
            void'(exp_q.pop_front());
            chk("ready_timeout", 64'(done), 64'd1);
        end
    endtask

    task automatic quiet(input int n, input logic [63:0] exp_hilo);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (div_readyE) pulses++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("no_ready_pulse", 64'(pulses), 64'd0);
        chk("hilo_held", hiloE, exp_hilo);
        chk("stall_idle", 64'(div_stallE), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Starts DIVU 100/7, then cancels it on ON cycle 10 by annul or by reset.
    task automatic cancel_test(input bit use_rst, input logic [63:0] exp_hilo);
        alucontrolE = DIVU;
        srca = 32'd100;
        srcb = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            annul = 1'b1;
            @(negedge clk);
            chk("annul_stall_drop", 64'(div_stallE), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        annul = 1'b0;
        alucontrolE = ADD;
        quiet(40, exp_hilo);
    endtask

    initial begin
        logic [63:0] exp;
        int rdy;
        logic [7:0] op;
        logic [31:0] a, b;

        rst = 1'b1;
        alucontrolE = ADD;
        srca = '0;
        srcb = '0;
        annul = 1'b0;
        holdE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(div_readyE), 64'd0);
        chk("reset_stall", 64'(div_stallE), 64'd0);
        chk("reset_hilo", hiloE, 64'd0);
        @(posedge clk);
        #1;

        run_div(DIVU, 32'd100, 32'd7, 33);
        run_div(DIV, 32'hFFFF_FFF9, 32'd2, 33);
        run_div(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33);
        run_div(DIVU, 32'h0000_1234, 32'd0, 1);
        run_div(DIV, 32'hFFFF_FFFB, 32'd0, 1);

        cancel_test(1'b0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        cancel_test(1'b1, 64'd0);

        // Annul in IDLE blocks the start entirely.
        alucontrolE = DIV;
        srca = 32'd50;
        srcb = 32'd5;
        annul = 1'b1;
        @(negedge clk);
        chk("idle_annul_stall", 64'(div_stallE), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        alucontrolE = ADD;
        quiet(40, 64'd0);

        // DIVU 9/4 with holdE raised during ON and kept for three DONE cycles.
        exp_q.push_back(model(DIVU, 32'd9, 32'd4));
        alucontrolE = DIVU;
        srca = 32'd9;
        srcb = 32'd4;
        repeat (20) @(posedge clk);
        #1;
        holdE = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (div_readyE) break;
            @(posedge clk);
            #1;
        end
        exp = exp_q.pop_front();
        rdy = 0;
        while (div_readyE && rdy < 10) begin
            rdy++;
            chk("hold_hilo", hiloE, exp);
            @(posedge clk);
            #1;
            if (rdy == 3) begin
                holdE = 1'b0;
                alucontrolE = ADD;
            end
            @(negedge clk);
        end
        chk("hold_ready_cycles", 64'(rdy), 64'd4);
        chk("hold_exit_stall", 64'(div_stallE), 64'd0);
        chk("hold_hilo_after", hiloE, {32'd1, 32'd2});
        @(posedge clk);
        #1;
        holdE = 1'b0;
        alucontrolE = ADD;

        for (int n = 0; n < 1000; n++) begin
            op = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (b == 32'd0) b = 32'd1;
            run_div(op, a, b, 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
